// File: rtl/victim_way_ctrl_pkg.sv
// Shared cache constants and the victim controller FSM state type.
package victim_way_ctrl_pkg;
  localparam int NUM_SETS = 8;
  localparam int NUM_WAYS = 8;
  localparam int WAY_W    = 3;
  localparam int SET_W    = 3;
  localparam int STAT_W   = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } vstate_t;
endpackage

// File: rtl/victim_way_ctrl_pick8.sv
// Per-set victim chooser: lowest invalid way, else the round-robin pointer.
module victim_pick8
  import victim_way_ctrl_pkg::*;
(
  input  logic [NUM_WAYS-1:0] valid,
  input  logic [WAY_W-1:0]    rr_ptr,
  output logic [WAY_W-1:0]    victim
);

  logic found_s;

  // Priority scan from way 0 upward for the first free slot
  always_comb begin
    victim  = rr_ptr;
    found_s = 1'b0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (!valid[i] && !found_s) begin
        victim  = WAY_W'(i);
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/victim_way_ctrl.sv
// Replacement state and miss-fill sequencer for the 8-set, 8-way cache.
// Optional miss counter enabled by defining VICTIM_STATS_EN.
module victim_way_ctrl
  import victim_way_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             acc_valid,
  output logic             acc_ready,
  input  logic [SET_W-1:0] acc_set,
  input  logic             acc_hit,
  output logic             fill_req,
  output logic [SET_W-1:0] fill_set,
  output logic [WAY_W-1:0] fill_way,
  input  logic             fill_done,
  input  logic             inv_valid,
  input  logic [SET_W-1:0] inv_set,
  input  logic [WAY_W-1:0] inv_way,
  output logic [WAY_W-1:0] victim0,
  output logic [WAY_W-1:0] victim1,
  output logic [WAY_W-1:0] victim2,
  output logic [WAY_W-1:0] victim3,
  output logic [WAY_W-1:0] victim4,
  output logic [WAY_W-1:0] victim5,
  output logic [WAY_W-1:0] victim6,
  output logic [WAY_W-1:0] victim7,
  output logic             busy
`ifdef VICTIM_STATS_EN
  ,
  output logic [STAT_W-1:0] miss_count
`endif
);

  vstate_t             state_r;
  vstate_t             state_nxt_s;
  logic [NUM_WAYS-1:0] valid_r [NUM_SETS];
  logic [WAY_W-1:0]    rr_r    [NUM_SETS];
  logic [WAY_W-1:0]    victim_s[NUM_SETS];
  logic [SET_W-1:0]    fill_set_r;
  logic [WAY_W-1:0]    fill_way_r;
  logic                full_at_latch_r;
  logic                miss_accept_s;
  logic                fill_commit_s;

  assign miss_accept_s = (state_r == IDLE) && acc_valid && !acc_hit;
  assign fill_commit_s = (state_r == FILL) && fill_done;

  for (genvar g = 0; g < NUM_SETS; g++) begin : g_pick
    victim_pick8 u_pick (
      .valid  (valid_r[g]),
      .rr_ptr (rr_r[g]),
      .victim (victim_s[g])
    );
  end

  assign victim0  = victim_s[0];
  assign victim1  = victim_s[1];
  assign victim2  = victim_s[2];
  assign victim3  = victim_s[3];
  assign victim4  = victim_s[4];
  assign victim5  = victim_s[5];
  assign victim6  = victim_s[6];
  assign victim7  = victim_s[7];
  assign fill_set = fill_set_r;
  assign fill_way = fill_way_r;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    if (miss_accept_s) state_nxt_s = FILL; else state_nxt_s = IDLE;
      FILL:    if (fill_done)     state_nxt_s = IDLE; else state_nxt_s = FILL;
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM outputs decoded from the state register
  always_comb begin
    acc_ready = 1'b1;
    busy      = 1'b0;
    fill_req  = 1'b0;
    case (state_r)
      IDLE: begin
        acc_ready = 1'b1;
        busy      = 1'b0;
        fill_req  = 1'b0;
      end
      FILL: begin
        acc_ready = 1'b0;
        busy      = 1'b1;
        fill_req  = 1'b1;
      end
      default: begin
        acc_ready = 1'b1;
        busy      = 1'b0;
        fill_req  = 1'b0;
      end
    endcase
  end

  // Fill latch, valid bitmap and round-robin pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_set_r      <= 3'd0;
      fill_way_r      <= 3'd0;
      full_at_latch_r <= 1'b0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_r[s] <= 8'h00;
        rr_r[s]    <= 3'd0;
      end
    end else begin
      if (miss_accept_s) begin
        fill_set_r      <= acc_set;
        fill_way_r      <= victim_s[acc_set];
        full_at_latch_r <= &valid_r[acc_set];
      end
      if (inv_valid) begin
        valid_r[inv_set][inv_way] <= 1'b0;
      end
      // Written after the invalidate so a colliding fill wins
      if (fill_commit_s) begin
        valid_r[fill_set_r][fill_way_r] <= 1'b1;
        if (full_at_latch_r) begin
          rr_r[fill_set_r] <= fill_way_r + 3'd1;
        end
      end
    end
  end

`ifdef VICTIM_STATS_EN
  logic [STAT_W-1:0] miss_count_r;

  // Saturating count of accepted misses
  always_ff @(posedge clk) begin
    if (rst) begin
      miss_count_r <= {STAT_W{1'b0}};
    end else if (miss_accept_s && (miss_count_r != {STAT_W{1'b1}})) begin
      miss_count_r <= miss_count_r + {{(STAT_W-1){1'b0}}, 1'b1};
    end
  end

  assign miss_count = miss_count_r;
`endif

endmodule

// File: tb/tb_victim_way_ctrl.sv
// Directed self-checking bench for victim_way_ctrl; inputs and samples on the falling edge.
module tb_victim_way_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       acc_valid = 1'b0, acc_hit = 1'b0, fill_done = 1'b0, inv_valid = 1'b0;
  logic [2:0] acc_set = 3'd0, inv_set = 3'd0, inv_way = 3'd0;
  logic       acc_ready, fill_req, busy;
  logic [2:0] fill_set, fill_way;
  logic [2:0] vic [8];
`ifdef VICTIM_STATS_EN
  logic [15:0] miss_count;
`endif
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  victim_way_ctrl dut (
    .clk(clk), .rst(rst),
    .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_set(acc_set), .acc_hit(acc_hit),
    .fill_req(fill_req), .fill_set(fill_set), .fill_way(fill_way), .fill_done(fill_done),
    .inv_valid(inv_valid), .inv_set(inv_set), .inv_way(inv_way),
    .victim0(vic[0]), .victim1(vic[1]), .victim2(vic[2]), .victim3(vic[3]),
    .victim4(vic[4]), .victim5(vic[5]), .victim6(vic[6]), .victim7(vic[7]),
    .busy(busy)
`ifdef VICTIM_STATS_EN
    , .miss_count(miss_count)
`endif
  );

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One miss on set s expecting way w; fill_done arrives dly cycles after the latch edge.
  task automatic do_miss(input logic [2:0] s, input logic [2:0] w, input int dly);
    @(negedge clk);
    check_eq("ready_before_miss", acc_ready, 1);
    acc_valid = 1'b1; acc_set = s; acc_hit = 1'b0;
    @(negedge clk);
    acc_valid = 1'b0;
    check_eq("fill_req_on", fill_req, 1);
    check_eq("busy_on", busy, 1);
    check_eq("ready_off", acc_ready, 0);
    check_eq("fill_set", fill_set, s);
    check_eq("fill_way", fill_way, w);
    repeat (dly - 1) @(negedge clk);
    check_eq("fill_way_held", fill_way, w);
    fill_done = 1'b1;
    @(negedge clk);
    fill_done = 1'b0;
    check_eq("fill_req_off", fill_req, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) check_eq($sformatf("reset_victim%0d", i), vic[i], 0);
    check_eq("reset_ready", acc_ready, 1);
    check_eq("reset_fill_req", fill_req, 0);
    check_eq("reset_busy", busy, 0);

    // Set 2: three misses fill invalid ways 0,1,2
    do_miss(3'd2, 3'd0, 3);
    do_miss(3'd2, 3'd1, 3);
    do_miss(3'd2, 3'd2, 3);
    check_eq("victim2_after3", vic[2], 3);

    // Hit does not leave IDLE
    acc_valid = 1'b1; acc_set = 3'd2; acc_hit = 1'b1;
    @(negedge clk);
    acc_valid = 1'b0; acc_hit = 1'b0;
    check_eq("hit_ready", acc_ready, 1);
    check_eq("hit_no_req", fill_req, 0);

    // Set 5: fill all ways, then two round-robin replacements
    for (int w = 0; w < 8; w++) do_miss(3'd5, 3'(w), 1);
    check_eq("victim5_full_rr0", vic[5], 0);
    do_miss(3'd5, 3'd0, 1);
    check_eq("victim5_rr1", vic[5], 1);
    do_miss(3'd5, 3'd1, 2);
    check_eq("victim5_rr2", vic[5], 2);

    // Invalidate way 6 of full set 5; fill to it leaves pointer at 2
    @(negedge clk);
    inv_valid = 1'b1; inv_set = 3'd5; inv_way = 3'd6;
    @(negedge clk);
    inv_valid = 1'b0;
    check_eq("victim5_inv6", vic[5], 6);
    do_miss(3'd5, 3'd6, 1);
    check_eq("victim5_rr_kept", vic[5], 2);

    // Set 1: fill ways 0..3, then colliding fill and invalidate of way 4
    for (int w = 0; w < 4; w++) do_miss(3'd1, 3'(w), 1);
    check_eq("victim1_is4", vic[1], 4);
    @(negedge clk);
    acc_valid = 1'b1; acc_set = 3'd1; acc_hit = 1'b0;
    @(negedge clk);
    acc_valid = 1'b0;
    check_eq("set1_fill_way", fill_way, 4);
    fill_done = 1'b1; inv_valid = 1'b1; inv_set = 3'd1; inv_way = 3'd4;
    @(negedge clk);
    fill_done = 1'b0; inv_valid = 1'b0;
    check_eq("collide_victim1", vic[1], 5);
    check_eq("collide_req_off", fill_req, 0);

    // Reset during a fill aborts it; late fill_done is ignored
    @(negedge clk);
    acc_valid = 1'b1; acc_set = 3'd3; acc_hit = 1'b0;
    @(negedge clk);
    acc_valid = 1'b0;
    check_eq("pre_rst_req", fill_req, 1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_req_drop", fill_req, 0);
    rst = 1'b0;
    fill_done = 1'b1;
    @(negedge clk);
    fill_done = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) check_eq($sformatf("post_rst_victim%0d", i), vic[i], 0);
    check_eq("post_rst_req", fill_req, 0);
    check_eq("post_rst_ready", acc_ready, 1);

`ifdef VICTIM_STATS_EN
    check_eq("stats_reset", miss_count, 0);
    do_miss(3'd0, 3'd0, 1);
    do_miss(3'd0, 3'd1, 2);
    do_miss(3'd0, 3'd2, 1);
    check_eq("stats_three", miss_count, 3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/victim_way_ctrl.md
Name: victim_way_ctrl

Overview:
- Per-set replacement-state block for the 8-set, 8-way set-associative cache.
- Holds a valid bitmap and a round-robin pointer for each set.
- Drives eight 3-bit victim-way candidates, one per set, into the downstream 8:1 3-bit victim mux, which selects by set index.
- Sequences miss fills with a request/done handshake toward the fill engine.

Parameters:
- NUM_SETS, 8, number of sets; fixed at 8 to match the 8:1 victim mux.
- WAY_W, 3, way index width (8 ways).
- STAT_W, 16, miss-counter width; used only with the optional feature.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- acc_valid  input  1  lookup result presented
- acc_ready  output  1  block can accept a lookup result
- acc_set  input  3  set index of the access
- acc_hit  input  1  1 = hit, 0 = miss
- fill_req  output  1  fill request to the fill engine
- fill_set  output  3  set being filled
- fill_way  output  3  way being filled
- fill_done  input  1  fill engine completed the fill (single-cycle pulse)
- inv_valid  input  1  invalidate request
- inv_set  input  3  set to invalidate
- inv_way  input  3  way to invalidate
- victim0..victim7  output  3 each  victim candidate for sets 0..7; feeds the victim mux inputs in0..in7
- busy  output  1  fill in progress

Behaviour:
- Reset, synchronous on rst=1:
  - state=IDLE, all valid bits=0, all round-robin pointers=0.
  - fill_req=0, fill_set=0, fill_way=0, busy=0, acc_ready=1.
  - victimN=0 for every set.
  - Reset asserted mid-fill aborts the fill: fill_req drops the next cycle and the in-flight fill_done is ignored.
- victimN is combinational from registered state:
  - If any valid bit of set N is 0, victimN = lowest-numbered invalid way.
  - Otherwise victimN = rr_ptr[N].
- State IDLE (acc_ready=1, busy=0):
  - acc_valid & acc_hit: no state change; stays IDLE, so hits have zero-cycle occupancy.
  - acc_valid & !acc_hit: latch fill_set=acc_set and fill_way=victim[acc_set] at that edge; go to FILL.
- State FILL (acc_ready=0, busy=1, fill_req=1):
  - fill_set and fill_way are held stable until fill_done.
  - acc_valid is ignored while acc_ready=0; the upstream holds the access.
- On fill_done in FILL:
  - valid[fill_set][fill_way] <= 1.
  - If the set was full at latch time, rr_ptr[fill_set] <= fill_way+1, wrapping 7 to 0.
  - If an invalid way was used, rr_ptr is unchanged.
  - Go to IDLE with fill_req=0 next cycle. Minimum miss occupancy is 2 cycles (latch, then done).
- fill_done outside FILL is ignored.
- Invalidate: inv_valid clears valid[inv_set][inv_way] in any state.
  - If it coincides with fill_done for the same set and way, the fill wins and the bit ends at 1.
  - An invalidate of the latched way during FILL does not change fill_way.
- Width rules: all indices are 3-bit unsigned; pointer increment is modulo 8.

Optional Feature:
- Macro: VICTIM_STATS_EN
- When defined:
  - Adds output miss_count [STAT_W-1:0], reset 0.
  - Increments on each accepted miss (IDLE & acc_valid & !acc_hit).
  - Saturates at all-ones.
- When undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared cache package holds:
  - NUM_SETS, NUM_WAYS, WAY_W, SET_W constants.
  - The state enum for the victim controller's FSM states (IDLE, FILL).
- One natural sub-module: victim_pick8, a combinational per-set chooser (8-bit valid map + 3-bit rr_ptr -> 3-bit victim), instantiated 8 times.

Test Plan:
- Reset, then read all victims -> victim0..7 = 0, acc_ready=1, fill_req=0.
- Miss set 2 with fill_done after 3 cycles, repeated 3 times:
  - fill_way = 0, 1, 2 in turn.
  - victim2 = 3 afterwards.
  - rr_ptr[2] stays 0.
- Fill all 8 ways of set 5, then miss set 5 twice:
  - fill_way = 0 then 1.
  - rr_ptr[5] = 2.
  - victim5 = 2.
- Set 5 full, inv_set=5 and inv_way=6 -> victim5 = 6 next cycle; next miss on set 5 fills way 6 and rr_ptr is unchanged.
- Miss set 1 (victim 4) with fill_done and inv_valid on set 1 way 4 in the same cycle -> valid bit = 1 and victim1 = 5.
- Assert rst during FILL -> fill_req=0 next cycle; a fill_done then arriving leaves all valid bits 0. With VICTIM_STATS_EN defined, 3 misses give miss_count=3.
